oam_dma: RTL and testbench

- Sprite DMA controller for the host CPU bus. A CPU write to the trigger register stalls the core through its ready input and takes ownership of the CPU bus.
- While it owns the bus, it copies P_count bytes from CPU page {page,8'h00} into the PPU OAM data port, alternating one read cycle and one write cycle.
- It sits between the core and the address decode/data mux, and drives the bus-owner select for the address/data/strobe muxes.

---
 rtl/oam_dma.sv | 89 ++++++++
 tb/tb_oam_dma.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// oam_dma: sprite DMA that stalls the CPU and copies one page into the PPU OAM data port
module oam_dma #(
  parameter logic [15:0] P_trigger_addr  = 16'h4014,
  parameter logic [15:0] P_oam_data_addr = 16'h2004,
  parameter int          P_count         = 256
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_phy2,
  input  logic [15:0] I_cpu_addr,
  input  logic        I_cpu_rdwr,
  input  logic [7:0]  I_cpu_data,
  output logic        O_ready,
  output logic        O_owner,
  output logic [15:0] O_addr,
  output logic        O_rden,
  output logic        O_wren,
  output logic [7:0]  O_data,
  input  logic [7:0]  I_rd_data,
  output logic        O_busy
);
  typedef enum logic [2:0] {S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE} state_t;
  localparam logic [7:0] LAST = 8'(P_count - 1);
  state_t      state_q, state_d;
  logic        parity_q, parity_d;
  logic        pend_q, pend_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  index_q, index_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] addr_q, addr_d;
  logic        trig;
  // next state, page latch and byte index, all advancing only on a CPU tick
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    index_d  = index_q;
    parity_d = parity_q ^ I_phy2;
    trig     = I_phy2 & ~I_cpu_rdwr & (I_cpu_addr == P_trigger_addr);
    if (I_phy2)
      case (state_q)
        S_IDLE:  if (trig) begin
          state_d = S_HALT;
          page_d  = I_cpu_data;
          index_d = 8'd0;
        end
        S_HALT:  if (I_cpu_rdwr) state_d = parity_q ? S_READ : S_ALIGN;
        S_ALIGN: state_d = S_READ;
        S_READ:  state_d = S_WRITE;
        S_WRITE: begin
          state_d = (index_q == LAST) ? S_IDLE : S_READ;
          index_d = (index_q == LAST) ? index_q : index_q + 8'd1;
        end
        default: state_d = S_IDLE;
      endcase
  end
  // bus-side outputs; read data lands one clock after the read strobe (registered memory)
  always_comb begin
    O_busy  = state_q != S_IDLE;
    O_ready = ~O_busy;
    O_owner = state_q == S_ALIGN || state_q == S_READ || state_q == S_WRITE;
    O_rden  = (state_q == S_READ) & I_phy2;
    O_wren  = (state_q == S_WRITE) & I_phy2;
    O_addr  = (state_q == S_READ) ? {page_q, index_q} : (state_q == S_WRITE) ? P_oam_data_addr : addr_q;
    O_data  = data_q;
    addr_d  = O_addr;
    pend_d  = O_rden;
    data_d  = pend_q ? I_rd_data : data_q;
  end
  // state register; reset wins over a trigger in the same clock
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      state_q  <= S_IDLE;
      parity_q <= 1'b0;
      pend_q   <= 1'b0;
      page_q   <= 8'd0;
      index_q  <= 8'd0;
      data_q   <= 8'd0;
      addr_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      parity_q <= parity_d;
      pend_q   <= pend_d;
      page_q   <= page_d;
      index_q  <= index_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
    end
  end
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: randomized scoreboard bench for oam_dma (full-page and 4-byte instances)
module tb_oam_dma;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic phy2 = 1'b0;
  logic par = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic cpu_rdwr = 1'b1;
  logic [7:0] cpu_data = 8'h00;
  logic [1:0] ready, owner, rden, wren, busy;
  logic [1:0][15:0] oaddr;
  logic [1:0][7:0] odata, rdd;
  logic [7:0] mem [65536];
  logic [15:0] qa[$];
  logic [7:0] qd[$];
  int checks = 0;
  int errors = 0;
  int stall[2];
  int act = 0;

  oam_dma dut0 (.I_clock(clk), .I_reset(rst), .I_phy2(phy2), .I_cpu_addr(cpu_addr),
    .I_cpu_rdwr(cpu_rdwr), .I_cpu_data(cpu_data), .O_ready(ready[0]), .O_owner(owner[0]),
    .O_addr(oaddr[0]), .O_rden(rden[0]), .O_wren(wren[0]), .O_data(odata[0]),
    .I_rd_data(rdd[0]), .O_busy(busy[0]));
  oam_dma #(.P_trigger_addr(16'h4016), .P_count(4)) dut1 (.I_clock(clk), .I_reset(rst),
    .I_phy2(phy2), .I_cpu_addr(cpu_addr), .I_cpu_rdwr(cpu_rdwr), .I_cpu_data(cpu_data),
    .O_ready(ready[1]), .O_owner(owner[1]), .O_addr(oaddr[1]), .O_rden(rden[1]),
    .O_wren(wren[1]), .O_data(odata[1]), .I_rd_data(rdd[1]), .O_busy(busy[1]));

  always #5 clk = ~clk;

  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      cnt = (cnt + 1) % 3;
      phy2 = (cnt == 2);
    end
  end

  always @(posedge clk) par <= rst ? 1'b0 : par ^ phy2;

  always @(posedge clk)
    for (int g = 0; g < 2; g++)
      if (rden[g]) rdd[g] <= mem[oaddr[g]];

  always @(negedge clk)
    if (!rst)
      for (int g = 0; g < 2; g++) begin
        logic [15:0] ea;
        logic [7:0] ed;
        if (phy2 && !ready[g]) stall[g]++;
        if (rden[g]) begin
          checks++;
          if (g != act || qa.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected dut%0d: got read of %h, required none", g, oaddr[g]);
          end else begin
            ea = qa.pop_front();
            if (oaddr[g] !== ea || owner[g] !== 1'b1) begin
              errors++;
              $display("FAIL rd_addr dut%0d: got %h owner %b, required %h owner 1", g, oaddr[g], owner[g], ea);
            end
          end
        end
        if (wren[g]) begin
          checks++;
          if (g != act || qd.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected dut%0d: got write %h to %h, required none", g, odata[g], oaddr[g]);
          end else begin
            ed = qd.pop_front();
            if (oaddr[g] !== 16'h2004 || odata[g] !== ed || owner[g] !== 1'b1) begin
              errors++;
              $display("FAIL wr_data dut%0d: got %h@%h, required %h@2004", g, odata[g], oaddr[g], ed);
            end
          end
        end
      end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic cpu_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d);
    cpu_addr = a;
    cpu_rdwr = rw;
    cpu_data = d;
    do @(posedge clk); while (!phy2);
    #2;
  endtask

  task automatic run(input int k, input logic [7:0] page, input logic odd, input int nw,
                     input int rst_at, input int badw);
    int n, it;
    logic hp;
    logic [15:0] trig;
    n = k ? 4 : 256;
    trig = k ? 16'h4016 : 16'h4014;
    while (par != odd) cpu_cycle(16'h0000, 1'b1, 8'h00);
    act = k;
    qa.delete();
    qd.delete();
    for (int i = 0; i < n; i++) begin
      qa.push_back({page, 8'(i)});
      qd.push_back(mem[{page, 8'(i)}]);
    end
    stall[k] = 0;
    cpu_cycle(trig, 1'b0, page);
    check("busy_after_trigger", busy[k], 1);
    check("ready_after_trigger", ready[k], 0);
    for (int j = 0; j < nw; j++) begin
      cpu_cycle(j == 0 ? trig : j == 1 ? 16'h4015 : 16'h0300, 1'b0, 8'h55);
      check("halt_owner", owner[k], 0);
      check("halt_busy", busy[k], 1);
    end
    hp = par;
    it = 0;
    while (!ready[k] && it < 700) begin
      if (rst_at > 0 && qa.size() == n - rst_at) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready[k], 1);
        check("rst_owner", owner[k], 0);
        check("rst_strobes", {rden[k], wren[k]}, 0);
        check("rst_busy", busy[k], 0);
        rst = 1'b0;
        qa.delete();
        qd.delete();
        return;
      end
      cpu_cycle(it == badw ? trig : 16'h0000, it != badw, 8'hAA);
      it++;
    end
    check("stall_cycles", stall[k], 1 + nw + 2 * n + (hp ? 0 : 1));
    check("bytes_left", qa.size() + qd.size(), 0);
    check("end_owner", owner[k], 0);
    check("end_busy", busy[k], 0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i);
    repeat (4) @(posedge clk);
    #2;
    for (int g = 0; g < 2; g++) begin
      check("reset_ready", ready[g], 1);
      check("reset_owner_busy", {owner[g], busy[g]}, 0);
      check("reset_addr", oaddr[g], 0);
      check("reset_data", odata[g], 0);
    end
    rst = 1'b0;
    cpu_cycle(16'h0000, 1'b1, 8'h00);
    run(0, 8'h02, 1'b0, 0, 0, -1);
    run(0, 8'h02, 1'b1, 0, 0, -1);
    run(0, 8'h03, 1'($urandom), 3, 0, 10);
    run(0, 8'($urandom), 1'b0, 0, 100, -1);
    run(0, 8'($urandom), 1'($urandom), 0, 0, -1);
    run(1, 8'h80, 1'b0, 0, 0, -1);
    run(1, 8'h80, 1'b1, 0, 0, -1);
    repeat (6) run(1, 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 0, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
